note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Producer side of the tone generator's TONE/VOL interface: queues note commands (tone code, volume, duration) and drives TONE/VOL for each note's exact duration.
- Inserts a configurable silent articulation gap between notes.
- Sits between the control/song-reader logic (valid/ready push) and the PWM tone generator (TONE/VOL consumer).

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- TICK_HZ, 1000, duration tick rate (1 ms); TICK_CYCLES = CLK_HZ/TICK_HZ, must be >= 2.
- FIFO_DEPTH, 8, note queue entries, power of two, >= 2.
- GAP_TICKS, 10, silent ticks after each played note; 0 disables the gap.
- TONE_MAX, 48, highest playable tone code.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- NOTE_VALID  in  1  note command valid
- NOTE_READY  out  1  queue can accept; = !full && !FLUSH
- NOTE_TONE  in  6  tone code; 0 = rest
- NOTE_VOL  in  4  volume
- NOTE_DUR  in  12  duration in ticks
- PAUSE  in  1  level; freeze playback
- FLUSH  in  1  one-cycle pulse; drop queue and current note
- TONE  out  6  to tone generator
- VOL  out  4  to tone generator
- BUSY  out  1  state != IDLE or queue non-empty
- DONE  out  1  one-cycle pulse when the queue drains after playing
- LEVEL  out  $clog2(FIFO_DEPTH)+1  queue occupancy

Behaviour:
- Reset (synchronous, active-high): state IDLE, queue empty, TONE=0, VOL=0, DONE=0, BUSY=0, NOTE_READY=0 while RST is high. All counters are cleared.
- Push: an entry {tone, vol, dur} is written on any edge where NOTE_VALID && NOTE_READY. Push and pop in the same cycle are legal; LEVEL is unchanged in that case.
- States:
  - IDLE: TONE=0, VOL=0. If the queue is non-empty, pop and go to LOAD.
  - LOAD: if dur==0, discard the entry, then pop the next entry (stay in LOAD) or go to IDLE. Otherwise latch outputs, set remaining=dur, restart the prescaler, and go to PLAY.
  - PLAY: on each tick, decrement remaining. When remaining reaches 0, go to GAP if GAP_TICKS>0; otherwise go to IDLE/LOAD.
  - GAP: TONE=0, VOL=0 for GAP_TICKS ticks, then pop the next entry (go to LOAD) or go to IDLE.
- Output latching in LOAD:
  - TONE/VOL are registered outputs.
  - If tone==0 or tone>TONE_MAX: TONE=0, VOL=0, but the duration is still honoured.
- Latency: a note accepted at edge N into an empty, idle block appears on TONE/VOL after edge N+2.
- Timing:
  - Outputs hold for exactly dur*TICK_CYCLES cycles.
  - Back-to-back queued notes are spaced exactly (dur+GAP_TICKS)*TICK_CYCLES + 1 cycles apart, where the +1 is the LOAD cycle.
  - Each dur=0 entry costs 1 cycle with no output change.
- Prescaler: counts 0..TICK_CYCLES-1 and emits a tick on wrap. It restarts at every LOAD and at GAP entry.
- PAUSE high:
  - Prescaler, remaining counter, and gap counter freeze.
  - VOL is forced to 0; TONE is held.
  - No pops occur; pushes are still accepted.
  - On release, playback resumes with the remaining cycle count preserved exactly.
- FLUSH:
  - The next edge empties the queue, aborts the current note, forces TONE=0 and VOL=0, and sets state to IDLE.
  - NOTE_READY is 0 during the FLUSH cycle, so no push occurs.
  - No DONE pulse is produced. FLUSH has priority over PAUSE.
- DONE: pulses for one cycle on a transition into IDLE from PLAY/GAP/LOAD when the queue is empty and at least one note with dur>0 has played since the last IDLE. It is not raised on reset or flush.
- Full: NOTE_READY=0 and the input is ignored. Empty in IDLE: outputs stay silent.
- Reset mid-note: identical to the reset state on the next edge.

Decomposition:
- Package audio_pkg holds:
  - TONE_W=6, VOL_W=4, DUR_W=12
  - TONE_REST=0, TONE_MAX_DEFAULT=48
  - note entry struct {tone, vol, dur}
  - state enum {IDLE, LOAD, PLAY, GAP}
- Submodule note_fifo: synchronous FIFO of note entries with push/pop/full/empty/level and synchronous clear (driven by RST or FLUSH).

Test Plan (CLK_HZ=1000, TICK_HZ=100 → TICK_CYCLES=10, GAP_TICKS=2, FIFO_DEPTH=4):
- Single note tone=12, vol=8, dur=3 pushed at edge N → TONE=12/VOL=8 from N+2 for 30 cycles; then 0/0 for 20 cycles; IDLE; DONE pulses once; BUSY falls.
- Two notes (12,8,3) then (20,5,1) pushed back to back → second note starts exactly 51 cycles after the first; DONE pulses only after the second.
- Push 5 notes with NOTE_VALID held → 4 accepted, NOTE_READY low while full, LEVEL=4; the 5th is accepted only after the first pop.
- Entries tone=50 dur=2 and tone=0 dur=2 → TONE=0, VOL=0 for 20 cycles each plus gaps; dur=0 entry → skipped in 1 cycle, no output change.
- PAUSE high for 7 cycles mid-note (dur=3) → VOL=0 while paused, TONE held; total note time = 30+7 cycles.
- FLUSH mid-note with 2 queued → next edge TONE=0, VOL=0, LEVEL=0, BUSY=0, no DONE.
- RST asserted mid-note with 2 queued → next edge TONE=0, VOL=0, LEVEL=0, BUSY=0.

Source files
------------

// File: rtl/note_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared widths, constants and types for the note sequencer and the
// tone-generator interface it feeds.
//   TONE_W / VOL_W / DUR_W : field widths of a note command
//   TONE_REST              : tone code meaning "silence"
//   TONE_MAX_DEFAULT       : highest playable tone code by default
//   note_t                 : one queued note {tone, vol, dur}
//   state_t                : playback state machine encoding
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int TONE_W           = 6;
    localparam int VOL_W            = 4;
    localparam int DUR_W            = 12;
    localparam int TONE_MAX_DEFAULT = 48;

    localparam logic [TONE_W-1:0] TONE_REST = '0;

    typedef struct packed {
        logic [TONE_W-1:0] tone;
        logic [VOL_W-1:0]  vol;
        logic [DUR_W-1:0]  dur;
    } note_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } state_t;

    // A tone is audible when it is not a rest and within the generator's range.
    function automatic logic tone_audible(input logic [TONE_W-1:0] tone,
                                          input int                tone_max);
        return (tone != TONE_REST) && (int'(tone) <= tone_max);
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// -----------------------------------------------------------------------------
// note_sequencer_if
// valid/ready push bus carrying note commands into the sequencer.
//   NOTE_VALID : producer has a command
//   NOTE_READY : sequencer accepts it on this edge
//   NOTE_TONE  : tone code (0 = rest)
//   NOTE_VOL   : volume
//   NOTE_DUR   : duration in ticks
// master = command producer (song reader), slave = sequencer.
// -----------------------------------------------------------------------------
interface note_sequencer_if;

    logic                          NOTE_VALID;
    logic                          NOTE_READY;
    logic [audio_pkg::TONE_W-1:0]  NOTE_TONE;
    logic [audio_pkg::VOL_W-1:0]   NOTE_VOL;
    logic [audio_pkg::DUR_W-1:0]   NOTE_DUR;

    modport master (
        output NOTE_VALID, NOTE_TONE, NOTE_VOL, NOTE_DUR,
        input  NOTE_READY
    );

    modport slave (
        input  NOTE_VALID, NOTE_TONE, NOTE_VOL, NOTE_DUR,
        output NOTE_READY
    );

endinterface

// File: rtl/note_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// note_fifo
// Synchronous FIFO of note entries with registered read data.
//   clk       : clock
//   clr       : synchronous clear (reset or flush), empties the queue
//   push      : write push_data (ignored when full)
//   push_data : entry to enqueue
//   pop       : advance the head (ignored when empty)
//   pop_data  : entry popped on the previous pop edge
//   full/empty/level : occupancy status
// -----------------------------------------------------------------------------
module note_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   push,
    input  note_t                  push_data,
    input  logic                   pop,
    output note_t                  pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    note_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    note_t          pop_data_q;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pop_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (pop_ok) pop_data_q <= mem[rd_ptr_q];
        end
    end

    // Storage has no reset so it can map onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = pop_data_q;
    assign level    = count_q;

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Queues note commands and drives TONE/VOL of the tone generator for each
// note's duration (in ticks of TICK_HZ), followed by a silent gap.
//   CLK, RST    : clock, synchronous active-high reset
//   note_in     : valid/ready note command bus (slave side)
//   PAUSE       : level, freezes playback and mutes VOL
//   FLUSH       : pulse, drops queue and the current note
//   TONE, VOL   : to tone generator
//   BUSY        : playing or queue non-empty
//   DONE        : one-cycle pulse when playback drains to idle
//   LEVEL       : queue occupancy
// -----------------------------------------------------------------------------
module note_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_HZ    = 1000,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_TICKS  = 10,
    parameter int TONE_MAX   = TONE_MAX_DEFAULT
) (
    input  logic                        CLK,
    input  logic                        RST,
    note_sequencer_if.slave             note_in,
    input  logic                        PAUSE,
    input  logic                        FLUSH,
    output logic [TONE_W-1:0]           TONE,
    output logic [VOL_W-1:0]            VOL,
    output logic                        BUSY,
    output logic                        DONE,
    output logic [$clog2(FIFO_DEPTH):0] LEVEL
);

    localparam int TICK_CYCLES = CLK_HZ / TICK_HZ;
    localparam int PW          = $clog2(TICK_CYCLES);
    localparam int GW          = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    state_t              state_q, state_d;
    logic [TONE_W-1:0]   tone_q, tone_d;
    logic [VOL_W-1:0]    vol_q, vol_d;
    logic [DUR_W-1:0]    rem_q, rem_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                played_q, played_d;
    logic                done_q, done_d;

    logic   ready;
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;
    note_t  push_entry;
    note_t  head;
    logic   tick;

    assign ready              = !fifo_full && !FLUSH && !RST;
    assign note_in.NOTE_READY = ready;
    assign fifo_push          = note_in.NOTE_VALID && ready;
    assign push_entry         = '{tone: note_in.NOTE_TONE,
                                  vol:  note_in.NOTE_VOL,
                                  dur:  note_in.NOTE_DUR};

    note_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (CLK),
        .clr       (RST || FLUSH),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (LEVEL)
    );

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d  = state_q;
        tone_d   = tone_q;
        vol_d    = vol_q;
        rem_d    = rem_q;
        presc_d  = presc_q;
        gap_d    = gap_q;
        played_d = played_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;

        if (FLUSH) begin
            state_d  = IDLE;
            tone_d   = '0;
            vol_d    = '0;
            rem_d    = '0;
            presc_d  = '0;
            gap_d    = '0;
            played_d = 1'b0;
        end else if (!PAUSE) begin
            // While paused nothing below runs: counters, state and pops freeze.
            unique case (state_q)
                IDLE: begin
                    tone_d   = '0;
                    vol_d    = '0;
                    played_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = LOAD;
                    end
                end
                LOAD: begin
                    // head holds the entry popped on the previous edge.
                    if (head.dur == '0) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = played_q;
                        end
                    end else begin
                        played_d = 1'b1;
                        state_d  = PLAY;
                        rem_d    = head.dur;
                        presc_d  = '0;
                        if (tone_audible(head.tone, TONE_MAX)) begin
                            tone_d = head.tone;
                            vol_d  = head.vol;
                        end else begin
                            tone_d = '0;
                            vol_d  = '0;
                        end
                    end
                end
                PLAY: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == DUR_W'(1)) begin
                            tone_d = '0;
                            vol_d  = '0;
                            if (GAP_TICKS > 0) begin
                                state_d = GAP;
                                gap_d   = GW'(GAP_TICKS);
                            end else if (!fifo_empty) begin
                                fifo_pop = 1'b1;
                                state_d  = LOAD;
                            end else begin
                                state_d = IDLE;
                                done_d  = played_q;
                            end
                        end
                    end
                end
                GAP: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        gap_d = gap_q - 1'b1;
                        if (gap_q == GW'(1)) begin
                            if (!fifo_empty) begin
                                fifo_pop = 1'b1;
                                state_d  = LOAD;
                            end else begin
                                state_d = IDLE;
                                done_d  = played_q;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            tone_q   <= '0;
            vol_q    <= '0;
            rem_q    <= '0;
            presc_q  <= '0;
            gap_q    <= '0;
            played_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tone_q   <= tone_d;
            vol_q    <= vol_d;
            rem_q    <= rem_d;
            presc_q  <= presc_d;
            gap_q    <= gap_d;
            played_q <= played_d;
            done_q   <= done_d;
        end
    end

    // Pause mutes immediately while the latched volume is kept for resume.
    assign TONE = tone_q;
    assign VOL  = PAUSE ? '0 : vol_q;
    assign BUSY = (state_q != IDLE) || !fifo_empty;
    assign DONE = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
// Directed and randomized checks of note_sequencer with TICK_CYCLES=10,
// GAP_TICKS=2, FIFO_DEPTH=4. Playback timelines are predicted from note
// lists: one LOAD cycle per entry, then dur*10 cycles of sound and 20
// silent cycles for every entry with dur>0, then IDLE with DONE.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

    localparam int TCYC = 10;
    localparam int GAPT = 2;
    localparam int TMAX = 48;

    typedef struct {
        int tone;
        int vol;
        int dur;
    } tb_note_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pause;
    logic       flush;
    logic [5:0] o_tone;
    logic [3:0] o_vol;
    logic       o_busy;
    logic       o_done;
    logic [2:0] o_level;

    int n_checks = 0;
    int n_fail   = 0;

    tb_note_t seq[$];

    always #5 clk = ~clk;

    note_sequencer_if nif();

    note_sequencer #(
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .FIFO_DEPTH (4),
        .GAP_TICKS  (GAPT),
        .TONE_MAX   (TMAX)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .note_in (nif.slave),
        .PAUSE   (pause),
        .FLUSH   (flush),
        .TONE    (o_tone),
        .VOL     (o_vol),
        .BUSY    (o_busy),
        .DONE    (o_done),
        .LEVEL   (o_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_note(input tb_note_t n);
        nif.NOTE_TONE  = 6'(n.tone);
        nif.NOTE_VOL   = 4'(n.vol);
        nif.NOTE_DUR   = 12'(n.dur);
        nif.NOTE_VALID = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_one(input tb_note_t n);
        bit ok = 1'b0;
        drive_note(n);
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = nif.NOTE_READY;
            @(posedge clk); #1;
        end
        nif.NOTE_VALID = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    function automatic tb_note_t mk(input int t, input int v, input int d);
        tb_note_t n;
        n.tone = t;
        n.vol  = v;
        n.dur  = d;
        return n;
    endfunction

    // Plays seq and compares every cycle against the predicted timeline.
    // prefill=1: queue everything while paused, then release.
    // prefill=0: stream entries on consecutive edges into an idle block.
    task automatic run_seq(input string tag, input bit prefill);
        int e_tone[$], e_vol[$], e_done[$], e_busy[$];
        bit played = 1'b0;
        int idx;
        bit aud;

        e_tone.push_back(0); e_vol.push_back(0); e_done.push_back(0); e_busy.push_back(1);
        foreach (seq[i]) begin
            e_tone.push_back(0); e_vol.push_back(0); e_done.push_back(0); e_busy.push_back(1);
            if (seq[i].dur > 0) begin
                played = 1'b1;
                aud = (seq[i].tone >= 1) && (seq[i].tone <= TMAX);
                for (int k = 0; k < seq[i].dur * TCYC; k++) begin
                    e_tone.push_back(aud ? seq[i].tone : 0);
                    e_vol.push_back(aud ? seq[i].vol : 0);
                    e_done.push_back(0); e_busy.push_back(1);
                end
                for (int k = 0; k < GAPT * TCYC; k++) begin
                    e_tone.push_back(0); e_vol.push_back(0); e_done.push_back(0); e_busy.push_back(1);
                end
            end
        end
        e_tone.push_back(0); e_vol.push_back(0); e_done.push_back(int'(played)); e_busy.push_back(0);
        e_tone.push_back(0); e_vol.push_back(0); e_done.push_back(0); e_busy.push_back(0);

        @(posedge clk); #1;
        if (prefill) begin
            pause = 1'b1;
            foreach (seq[i]) push_one(seq[i]);
            @(negedge clk);
            chk({tag, " level"}, 32'(o_level), seq.size());
            @(posedge clk); #1;
            pause = 1'b0;
            idx = seq.size();
        end else begin
            drive_note(seq[0]);
            @(posedge clk); #1;
            idx = 1;
            if (idx < seq.size()) begin drive_note(seq[idx]); idx++; end
            else nif.NOTE_VALID = 1'b0;
        end

        for (int c = 0; c < e_tone.size(); c++) begin
            @(negedge clk);
            chk($sformatf("%s tone c%0d", tag, c), 32'(o_tone), e_tone[c]);
            chk($sformatf("%s vol c%0d",  tag, c), 32'(o_vol),  e_vol[c]);
            chk($sformatf("%s done c%0d", tag, c), 32'(o_done), e_done[c]);
            chk($sformatf("%s busy c%0d", tag, c), 32'(o_busy), e_busy[c]);
            @(posedge clk); #1;
            if (idx < seq.size()) begin drive_note(seq[idx]); idx++; end
            else nif.NOTE_VALID = 1'b0;
        end
        $display("run %s: %0d notes, %0d cycles compared", tag, seq.size(), e_tone.size());
    endtask

    initial begin
        int on;
        int n;
        bit seen;
        tb_note_t x;

        rst = 1'b1; pause = 1'b0; flush = 1'b0;
        nif.NOTE_VALID = 1'b0; nif.NOTE_TONE = '0; nif.NOTE_VOL = '0; nif.NOTE_DUR = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst tone",  32'(o_tone),  0);
        chk("rst vol",   32'(o_vol),   0);
        chk("rst done",  32'(o_done),  0);
        chk("rst busy",  32'(o_busy),  0);
        chk("rst ready", 32'(nif.NOTE_READY), 0);
        chk("rst level", 32'(o_level), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post rst ready", 32'(nif.NOTE_READY), 1);

        // Single streamed note: latency 2, 30 cycles sound, 20 gap, DONE
        seq.delete(); seq.push_back(mk(12, 8, 3));
        run_seq("single", 1'b0);

        // Two back-to-back notes: starts 51 cycles apart, one DONE
        seq.delete(); seq.push_back(mk(12, 8, 3)); seq.push_back(mk(20, 5, 1));
        run_seq("pair", 1'b0);

        // Out-of-range tone, rest, zero-duration skip
        seq.delete();
        seq.push_back(mk(50, 7, 2)); seq.push_back(mk(0, 9, 2));
        seq.push_back(mk(33, 3, 0)); seq.push_back(mk(7, 4, 1));
        run_seq("rest_range", 1'b1);

        // Randomized note lists
        for (int r = 0; r < 6; r++) begin
            seq.delete();
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                x.tone = int'($urandom_range(0, 63));
                x.vol  = int'($urandom_range(0, 15));
                x.dur  = int'($urandom_range(0, 3));
                seq.push_back(x);
            end
            run_seq($sformatf("rand%0d", r), 1'b1);
        end

        // PAUSE for 7 cycles mid-note stretches the note to 37 cycles
        @(posedge clk); #1;
        push_one(mk(12, 8, 3));
        on = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_tone == 6'd12) break;
        end
        on = 1;
        repeat (9) begin
            @(negedge clk);
            if (o_tone == 6'd12) on++;
        end
        @(posedge clk); #1;
        pause = 1'b1;
        for (int p = 0; p < 7; p++) begin
            @(negedge clk);
            chk("pause vol",  32'(o_vol),  0);
            chk("pause tone", 32'(o_tone), 12);
            if (o_tone == 6'd12) on++;
            @(posedge clk); #1;
        end
        pause = 1'b0;
        @(negedge clk);
        chk("resume vol", 32'(o_vol), 8);
        if (o_tone == 6'd12) on++;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_tone == 6'd12) on++;
            else break;
        end
        chk("pause note length", on, 37);
        for (int k = 0; k < 40; k++) begin
            if (o_done) break;
            @(negedge clk);
        end
        chk("pause done", 32'(o_done), 1);
        @(negedge clk);
        chk("pause done width", 32'(o_done), 0);
        chk("pause busy end",   32'(o_busy), 0);
        $display("run pause: 1 note, length %0d cycles", on);

        // Full queue, then FLUSH mid-note
        @(posedge clk); #1;
        pause = 1'b1;
        push_one(mk(12, 8, 3)); push_one(mk(20, 5, 1));
        push_one(mk(30, 4, 2)); push_one(mk(40, 3, 1));
        drive_note(mk(9, 9, 1));
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            chk("full ready", 32'(nif.NOTE_READY), 0);
            chk("full level", 32'(o_level), 4);
            @(posedge clk); #1;
        end
        pause = 1'b0;
        @(negedge clk);
        chk("full ready before pop", 32'(nif.NOTE_READY), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready after pop", 32'(nif.NOTE_READY), 1);
        chk("level after pop", 32'(o_level), 3);
        @(posedge clk); #1;
        nif.NOTE_VALID = 1'b0;
        @(negedge clk);
        chk("fifth accepted level", 32'(o_level), 4);
        chk("fifth accepted tone",  32'(o_tone),  12);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush ready", 32'(nif.NOTE_READY), 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush tone",  32'(o_tone),  0);
        chk("flush vol",   32'(o_vol),   0);
        chk("flush level", 32'(o_level), 0);
        chk("flush busy",  32'(o_busy),  0);
        seen = o_done;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            seen = seen | o_done;
        end
        chk("flush no done", 32'(seen), 0);
        $display("run flush: 5 pushed, queue dropped");

        // Reset mid-note with two queued
        @(posedge clk); #1;
        push_one(mk(12, 8, 3)); push_one(mk(20, 5, 1)); push_one(mk(30, 4, 2));
        repeat (15) @(negedge clk);
        chk("prerst tone",  32'(o_tone),  12);
        chk("prerst level", 32'(o_level), 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst ready", 32'(nif.NOTE_READY), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst tone",  32'(o_tone),  0);
        chk("midrst vol",   32'(o_vol),   0);
        chk("midrst level", 32'(o_level), 0);
        chk("midrst busy",  32'(o_busy),  0);
        chk("midrst done",  32'(o_done),  0);
        $display("run reset: 3 pushed, reset mid-note");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
